// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scanned 7-segment lines in, decoded frame out
interface seg_scan_decoder_if;
   logic [3:0]  ano;
   logic [7:0]  cathodes;
   logic [15:0] value;
   logic        value_valid;
   logic        frame_done;
   logic        seg_error;

   modport master (
      output ano, cathodes,
      input  value, value_valid, frame_done, seg_error
   );

   modport slave (
      input  ano, cathodes,
      output value, value_valid, frame_done, seg_error
   );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a multiplexed 7-segment scan back into a 16-bit value
module seg_scan_decoder #(
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 1024
) (
   input logic              clk,
   input logic              res,
   seg_scan_decoder_if.slave bus
);

   localparam int SW = (SETTLE < 2) ? 2 : $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] SETTLE_M1  = SW'(SETTLE - 1);
   localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURED} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic [TW-1:0] timeout_cnt;
   logic [3:0]    ano_q, ano_p;
   logic [7:0]    cathodes_q, cathodes_p;
   logic [15:0]   shadow;
   logic [3:0]    seen_mask;
   logic          frame_bad;

   logic       sel;
   logic [1:0] digit;
   logic       legal;
   logic [3:0] nib;
   logic       changed;
   logic       sample;
   logic       complete;
   logic       good_complete;

   always_comb begin
      sel   = 1'b1;
      digit = 2'd0;
      case (ano_q)
         4'b1110: digit = 2'd0;
         4'b1101: digit = 2'd1;
         4'b1011: digit = 2'd2;
         4'b0111: digit = 2'd3;
         default: sel = 1'b0;
      endcase
   end

   // dp (bit 7) is ignored, so only the seven segment lines are matched
   always_comb begin
      legal = 1'b1;
      nib   = 4'h0;
      case (cathodes_q[6:0])
         7'h40: nib = 4'h0;
         7'h79: nib = 4'h1;
         7'h24: nib = 4'h2;
         7'h30: nib = 4'h3;
         7'h19: nib = 4'h4;
         7'h12: nib = 4'h5;
         7'h02: nib = 4'h6;
         7'h78: nib = 4'h7;
         7'h00: nib = 4'h8;
         7'h10: nib = 4'h9;
         7'h08: nib = 4'hA;
         7'h03: nib = 4'hB;
         7'h46: nib = 4'hC;
         7'h21: nib = 4'hD;
         7'h06: nib = 4'hE;
         7'h0E: nib = 4'hF;
         default: legal = 1'b0;
      endcase
   end

   assign changed       = (ano_q != ano_p) || (cathodes_q != cathodes_p);
   assign complete      = (seen_mask == 4'hF);
   assign good_complete = complete && !frame_bad;

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      sample     = 1'b0;
      case (state)
         S_IDLE: begin
            if (sel) begin
               state_nxt  = S_SETTLE;
               settle_nxt = SW'(1);
            end
         end
         S_SETTLE: begin
            if (!sel) begin
               state_nxt = S_IDLE;
            end else if (changed) begin
               settle_nxt = SW'(1);
            end else if (settle_cnt >= SETTLE_M1) begin
               sample    = 1'b1;
               state_nxt = S_CAPTURED;
            end else begin
               settle_nxt = settle_cnt + SW'(1);
            end
         end
         S_CAPTURED: begin
            // one sample per dwell; a changed segment pattern is resampled
            if (ano_q != ano_p) begin
               if (!sel) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt  = S_SETTLE;
                  settle_nxt = SW'(1);
               end
            end else if (cathodes_q != cathodes_p) begin
               state_nxt  = S_SETTLE;
               settle_nxt = SW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         ano_q           <= 4'hF;
         ano_p           <= 4'hF;
         cathodes_q      <= 8'hFF;
         cathodes_p      <= 8'hFF;
         shadow          <= '0;
         seen_mask       <= '0;
         frame_bad       <= 1'b0;
         timeout_cnt     <= '0;
         bus.value       <= '0;
         bus.value_valid <= 1'b0;
         bus.frame_done  <= 1'b0;
         bus.seg_error   <= 1'b0;
      end else begin
         ano_q      <= bus.ano;
         ano_p      <= ano_q;
         cathodes_q <= bus.cathodes;
         cathodes_p <= cathodes_q;

         bus.seg_error  <= sample && !legal;
         bus.frame_done <= good_complete;

         if (sample && legal)
            shadow[{digit, 2'b00} +: 4] <= nib;

         // a sample coinciding with completion starts the next frame
         if (complete) begin
            seen_mask <= sample ? (4'b0001 << digit) : 4'b0000;
            frame_bad <= sample && !legal;
         end else begin
            if (sample)
               seen_mask <= seen_mask | (4'b0001 << digit);
            if (sample && !legal)
               frame_bad <= 1'b1;
         end

         if (good_complete) begin
            bus.value       <= shadow;
            bus.value_valid <= 1'b1;
            timeout_cnt     <= '0;
         end else begin
            if (timeout_cnt != TIMEOUT_V)
               timeout_cnt <= timeout_cnt + TW'(1);
            if (timeout_cnt == TIMEOUT_M1)
               bus.value_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   seg_scan_decoder_if bus ();

   seg_scan_decoder #(.SETTLE(2), .TIMEOUT(1024)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int seg_err_seen = 0;
   logic [15:0] exp_q[$];

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!res) begin
         if (bus.seg_error)
            seg_err_seen++;
         if (bus.frame_done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame actual=%h required=none", bus.value);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               if (bus.value !== e || bus.value_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_value actual=%h valid=%b required=%h valid=1",
                           bus.value, bus.value_valid, e);
               end
            end
         end
      end
   end

   task automatic dwell(input int k, input logic [7:0] cat);
      logic [3:0] a;
      a = 4'b0001 << k;
      bus.ano      = ~a;
      bus.cathodes = cat;
      repeat (4) @(negedge clk);
   endtask

   task automatic blank(input int n);
      bus.ano      = 4'hF;
      bus.cathodes = 8'hFF;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [15:0] v, input logic [3:0] bad, input bit rev, input bit exp_ok);
      int k;
      if (exp_ok)
         exp_q.push_back(v);
      for (int i = 0; i < 4; i++) begin
         k = rev ? 3 - i : i;
         dwell(k, bad[k] ? 8'hFF : seg_tab[v[4*k +: 4]]);
      end
   endtask

   initial begin
      int n;
      bus.ano      = 4'hF;
      bus.cathodes = 8'hFF;
      repeat (3) @(negedge clk);
      chk("reset_value", {16'h0, bus.value}, 32'h0);
      chk("reset_valid", {31'h0, bus.value_valid}, 32'h0);
      chk("reset_frame_done", {31'h0, bus.frame_done}, 32'h0);
      chk("reset_seg_error", {31'h0, bus.seg_error}, 32'h0);
      res = 1'b0;

      // 1: plain scan, two frames
      scan(16'h1234, 4'b0000, 1'b0, 1'b1);
      scan(16'h1234, 4'b0000, 1'b0, 1'b1);
      blank(6);
      chk("t1_frames_drained", exp_q.size(), 0);
      chk("t1_valid", {31'h0, bus.value_valid}, 32'h1);

      // 2: illegal digit2 spoils one frame
      scan(16'h1234, 4'b0100, 1'b0, 1'b0);
      blank(6);
      chk("t2_seg_error_count", seg_err_seen, 1);
      chk("t2_value_kept", {16'h0, bus.value}, 32'h1234);
      scan(16'hABCD, 4'b0000, 1'b0, 1'b1);
      blank(6);
      chk("t2_value_abcd", {16'h0, bus.value}, 32'hABCD);

      // 3: unstable cathodes never sample digit0
      bus.ano = 4'b1110;
      for (int i = 0; i < 20; i++) begin
         bus.cathodes = i[0] ? seg_tab[2] : seg_tab[1];
         @(negedge clk);
      end
      dwell(1, seg_tab[7]);
      dwell(2, seg_tab[6]);
      dwell(3, seg_tab[5]);
      blank(10);
      chk("t3_no_early_frame", exp_q.size(), 0);
      exp_q.push_back(16'h5678);
      dwell(0, seg_tab[8]);
      blank(6);
      chk("t3_frames_drained", exp_q.size(), 0);
      chk("t3_value", {16'h0, bus.value}, 32'h5678);

      // 4: two-digit and blank anode patterns are ignored
      dwell(0, seg_tab[3]);
      dwell(1, seg_tab[2]);
      dwell(2, seg_tab[1]);
      bus.ano      = 4'b1100;
      bus.cathodes = seg_tab[9];
      repeat (50) @(negedge clk);
      blank(50);
      exp_q.push_back(16'h4123);
      dwell(3, seg_tab[4]);
      blank(6);
      chk("t4_frames_drained", exp_q.size(), 0);
      chk("t4_value", {16'h0, bus.value}, 32'h4123);
      chk("t4_seg_error_count", seg_err_seen, 1);

      // 6: reset mid-frame discards the partial frame
      dwell(0, seg_tab[1]);
      dwell(1, seg_tab[2]);
      dwell(2, seg_tab[3]);
      res = 1'b1;
      bus.ano      = 4'hF;
      bus.cathodes = 8'hFF;
      @(negedge clk);
      chk("t6_reset_value", {16'h0, bus.value}, 32'h0);
      chk("t6_reset_valid", {31'h0, bus.value_valid}, 32'h0);
      chk("t6_reset_frame_done", {31'h0, bus.frame_done}, 32'h0);
      chk("t6_reset_seg_error", {31'h0, bus.seg_error}, 32'h0);
      res = 1'b0;
      @(negedge clk);
      scan(16'h0F0F, 4'b0000, 1'b1, 1'b1);
      blank(6);
      chk("t6_frames_drained", exp_q.size(), 0);
      chk("t6_value", {16'h0, bus.value}, 32'h0F0F);

      // 5: value_valid times out 1024 cycles after frame_done
      blank(5);
      scan(16'hBEEF, 4'b0000, 1'b0, 1'b1);
      bus.ano      = 4'hF;
      bus.cathodes = 8'hFF;
      n = 0;
      while (!bus.frame_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_frame_done_seen", {31'h0, bus.frame_done}, 32'h1);
      n = 0;
      while (bus.value_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_valid_fall_cycles", n, 1024);
      chk("t5_value_held", {16'h0, bus.value}, 32'hBEEF);
      chk("t5_valid_low", {31'h0, bus.value_valid}, 32'h0);
      chk("final_frames_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
